reg_cmd_bridge: RTL and testbench

//  Command front-end for register_block: accepts read/write commands on a valid/ready stream,

---
 rtl/reg_cmd_bridge_pkg.sv | 32 +++
 rtl/reg_cmd_bridge.sv | 133 +++++++++++++
 tb/tb_reg_cmd_bridge.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_cmd_bridge_pkg.sv
// rtl/reg_cmd_bridge_pkg.sv - command opcodes, FSM states and RMW merge helper for reg_cmd_bridge
package reg_cmd_bridge_pkg;

  localparam int MERGE_W = 64;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_SET   = 2'b10,
    OP_CLR   = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_CAPTURE,
    WR,
    RESP
  } state_e;

  // Callers zero-extend to MERGE_W and truncate the result back to their data width.
  function automatic logic [MERGE_W-1:0] rmw_merge(input op_e op,
                                                   input logic [MERGE_W-1:0] rd,
                                                   input logic [MERGE_W-1:0] mask);
    case (op)
      OP_SET:  rmw_merge = rd | mask;
      OP_CLR:  rmw_merge = rd & ~mask;
      default: rmw_merge = rd;
    endcase
  endfunction

endpackage

// File: rtl/reg_cmd_bridge.sv
// rtl/reg_cmd_bridge.sv - stream command front-end driving register_block read/write ports
// SET/CLR read-modify-write is enabled by defining REG_CMD_BRIDGE_RMW_EN.
module reg_cmd_bridge
  import reg_cmd_bridge_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 16,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [AW-1:0]    cmd_addr,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic             w_en,
  output logic [AW-1:0]    w_addr,
  output logic [WIDTH-1:0] w_value,
  output logic             r_en,
  output logic [AW-1:0]    r_addr,
  input  logic [WIDTH-1:0] r_value
);

  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  state_e state;
  op_e    op_q;
  logic   addr_bad;
  logic   op_bad;

  assign addr_bad = {1'b0, cmd_addr} >= DEPTH_W;

`ifdef REG_CMD_BRIDGE_RMW_EN
  logic [WIDTH-1:0] data_q;
  assign op_bad = 1'b0;
`else
  assign op_bad = cmd_op[1];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      op_q      <= OP_READ;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      w_en      <= 1'b0;
      w_addr    <= '0;
      w_value   <= '0;
      r_en      <= 1'b0;
      r_addr    <= '0;
`ifdef REG_CMD_BRIDGE_RMW_EN
      data_q    <= '0;
`endif
    end else begin
      r_en <= 1'b0;
      w_en <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            op_q      <= op_e'(cmd_op);
`ifdef REG_CMD_BRIDGE_RMW_EN
            data_q    <= cmd_data;
`endif
            if (addr_bad || op_bad) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_data  <= '0;
            end else if (op_e'(cmd_op) == OP_WRITE) begin
              state   <= WR;
              w_en    <= 1'b1;
              w_addr  <= cmd_addr;
              w_value <= cmd_data;
            end else begin
              state  <= RD_ISSUE;
              r_en   <= 1'b1;
              r_addr <= cmd_addr;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        RD_ISSUE: state <= RD_CAPTURE;
        RD_CAPTURE: begin
`ifdef REG_CMD_BRIDGE_RMW_EN
          if (op_q == OP_READ) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_data  <= r_value;
          end else begin
            // r_addr still holds the command address, so it doubles as the write target.
            state   <= WR;
            w_en    <= 1'b1;
            w_addr  <= r_addr;
            w_value <= WIDTH'(rmw_merge(op_q, MERGE_W'(r_value), MERGE_W'(data_q)));
          end
`else
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_data  <= r_value;
`endif
        end
        WR: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_data  <= (op_q == OP_WRITE) ? '0 : w_value;
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_cmd_bridge.sv
// tb/tb_reg_cmd_bridge.sv - randomized self-checking bench for reg_cmd_bridge with a register file model
// Expectations follow REG_CMD_BRIDGE_RMW_EN when the bench is built with it defined.
module tb_reg_cmd_bridge;

`ifdef REG_CMD_BRIDGE_RMW_EN
  localparam bit RMW = 1'b1;
`else
  localparam bit RMW = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [3:0]  cmd_addr = 4'd0;
  logic [15:0] cmd_data = 16'h0;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_err;
  logic [15:0] rsp_data;
  logic        w_en, r_en;
  logic [3:0]  w_addr, r_addr;
  logic [15:0] w_value, r_value;

  logic        cmd_valid12 = 1'b0, cmd_ready12, rsp_valid12, rsp_err12, w_en12, r_en12;
  logic        rsp_ready12;
  logic [15:0] rsp_data12, w_value12, r_value12;
  logic [3:0]  w_addr12, r_addr12;
  assign rsp_ready12 = 1'b1;
  assign r_value12   = 16'h0;

  int n_cmp = 0;
  int n_fail = 0;
  int overlap = 0;
  logic [15:0] regs [16];
  logic [15:0] exp_mem [16];

  always #5 clk = ~clk;

  reg_cmd_bridge #(.WIDTH(16), .DEPTH(16)) u_dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .w_en(w_en), .w_addr(w_addr), .w_value(w_value),
    .r_en(r_en), .r_addr(r_addr), .r_value(r_value));

  reg_cmd_bridge #(.WIDTH(16), .DEPTH(12)) u_dut12 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid12), .cmd_ready(cmd_ready12), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .rsp_valid(rsp_valid12), .rsp_ready(rsp_ready12),
    .rsp_data(rsp_data12), .rsp_err(rsp_err12), .w_en(w_en12), .w_addr(w_addr12),
    .w_value(w_value12), .r_en(r_en12), .r_addr(r_addr12), .r_value(r_value12));

  // Stand-in for register_block: write on w_en, read data valid the cycle after r_en.
  always @(posedge clk) begin
    if (w_en) regs[w_addr] <= w_value;
    if (r_en) r_value <= regs[r_addr];
  end

  always @(negedge clk) if (!reset && r_en && w_en) overlap++;

  // Reference model: register file semantics plus the documented response latencies.
  task automatic model_cmd(input logic [1:0] op, input logic [3:0] addr, input logic [15:0] data,
                           output logic [15:0] d, output logic e, output int lat,
                           output int nw, output int nr);
    d = 16'h0; e = 1'b0; lat = 0; nw = 0; nr = 0;
    case (op)
      2'b00: begin d = exp_mem[addr]; lat = 3; nr = 1; end
      2'b01: begin exp_mem[addr] = data; lat = 2; nw = 1; end
      default: begin
        if (RMW) begin
          exp_mem[addr] = (op == 2'b10) ? (exp_mem[addr] | data) : (exp_mem[addr] & ~data);
          d = exp_mem[addr]; lat = 4; nw = 1; nr = 1;
        end else begin
          e = 1'b1; lat = 1;
        end
      end
    endcase
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [3:0] addr, input logic [15:0] data,
                        input int hold, output logic [15:0] d, output logic e, output int lat,
                        output int nw, output int nr, output int uns);
    int w = 0;
    rsp_ready = (hold == 0);
    while (cmd_ready !== 1'b1 && w < 20) begin @(posedge clk); #1; w++; end
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 0; nw = 0; nr = 0; uns = 0;
    while (lat < 50) begin
      lat++;
      if (w_en === 1'b1) nw++;
      if (r_en === 1'b1) nr++;
      if (rsp_valid === 1'b1) break;
      @(posedge clk); #1;
    end
    d = rsp_data; e = rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b1 || rsp_data !== d || rsp_err !== e || cmd_ready !== 1'b0) uns++;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({cmd_ready, rsp_valid, rsp_data, rsp_err, w_en, w_addr, w_value, r_en, r_addr} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs: got rdy=%b vld=%b data=%h err=%b wen=%b ren=%b, want all 0",
                 cmd_ready, rsp_valid, rsp_data, rsp_err, w_en, r_en);
      end
    end
    reset = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (cmd_ready !== 1'b1 || cmd_ready12 !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready_after: got %b/%b want 1/1", cmd_ready, cmd_ready12);
    end
  endtask

  task automatic test_write_read();
    logic [15:0] d, ed; logic e, ee; int lat, el, nw, nr, enw, enr, uns;
    for (int i = 0; i < 16; i++) begin
      model_cmd(2'b01, 4'(i), 16'(16'hA000 + i), ed, ee, el, enw, enr);
      do_cmd(2'b01, 4'(i), 16'(16'hA000 + i), 0, d, e, lat, nw, nr, uns);
      n_cmp++;
      if (d !== ed || e !== ee || lat !== el || nw !== enw || nr !== enr) begin
        n_fail++;
        $display("FAIL write_%0d: got d=%h e=%b lat=%0d nw=%0d nr=%0d want d=%h e=%b lat=%0d nw=%0d nr=%0d",
                 i, d, e, lat, nw, nr, ed, ee, el, enw, enr);
      end
    end
    for (int i = 0; i < 16; i++) begin
      model_cmd(2'b00, 4'(i), 16'h0, ed, ee, el, enw, enr);
      do_cmd(2'b00, 4'(i), 16'h0, 0, d, e, lat, nw, nr, uns);
      n_cmp++;
      if (d !== 16'(16'hA000 + i) || e !== 1'b0 || lat !== 3 || nr !== 1 || nw !== 0) begin
        n_fail++;
        $display("FAIL read_%0d: got d=%h e=%b lat=%0d nr=%0d nw=%0d want d=%h e=0 lat=3 nr=1 nw=0",
                 i, d, e, lat, nr, nw, 16'(16'hA000 + i));
      end
    end
  endtask

  task automatic test_rmw();
    logic [1:0]  ops [4]  = '{2'b01, 2'b10, 2'b11, 2'b00};
    logic [15:0] dats [4] = '{16'h00F0, 16'h0F01, 16'h00F1, 16'h0000};
    logic [15:0] want [4];
    logic [15:0] d, ed; logic e, ee; int lat, el, nw, nr, enw, enr, uns;
    want = '{16'h0000, RMW ? 16'h0FF1 : 16'h0000, RMW ? 16'h0F00 : 16'h0000,
             RMW ? 16'h0F00 : 16'h00F0};
    for (int k = 0; k < 4; k++) begin
      model_cmd(ops[k], 4'd5, dats[k], ed, ee, el, enw, enr);
      do_cmd(ops[k], 4'd5, dats[k], 0, d, e, lat, nw, nr, uns);
      n_cmp++;
      if (d !== want[k] || d !== ed || e !== ee || lat !== el || nw !== enw || nr !== enr) begin
        n_fail++;
        $display("FAIL rmw_step%0d: got d=%h e=%b lat=%0d nw=%0d nr=%0d want d=%h e=%b lat=%0d nw=%0d nr=%0d",
                 k, d, e, lat, nw, nr, want[k], ee, el, enw, enr);
      end
    end
  endtask

  task automatic test_out_of_range();
    logic [1:0] op; logic [3:0] a; logic exp_err; logic [15:0] d; logic e; int lat, nacc, w;
    for (int k = 0; k < 3; k++) begin
      op = (k == 1) ? 2'b00 : 2'b01;
      a = (k == 2) ? 4'd11 : 4'd13;
      exp_err = (k < 2);
      w = 0;
      while (cmd_ready12 !== 1'b1 && w < 20) begin @(posedge clk); #1; w++; end
      cmd_op = op; cmd_addr = a; cmd_data = 16'h1234; cmd_valid12 = 1'b1;
      @(posedge clk); #1;
      cmd_valid12 = 1'b0;
      lat = 0; nacc = 0;
      while (lat < 20) begin
        lat++;
        if (w_en12 === 1'b1) nacc++;
        if (r_en12 === 1'b1) nacc++;
        if (rsp_valid12 === 1'b1) break;
        @(posedge clk); #1;
      end
      d = rsp_data12; e = rsp_err12;
      @(posedge clk); #1;
      n_cmp++;
      if (e !== exp_err || d !== 16'h0 || lat !== (exp_err ? 1 : 2) || nacc !== (exp_err ? 0 : 1)) begin
        n_fail++;
        $display("FAIL range_op%0d_addr%0d: got e=%b d=%h lat=%0d acc=%0d want e=%b d=0000 lat=%0d acc=%0d",
                 op, a, e, d, lat, nacc, exp_err, exp_err ? 1 : 2, exp_err ? 0 : 1);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] d, ed; logic e, ee; int lat, el, nw, nr, enw, enr, uns;
    model_cmd(2'b00, 4'd9, 16'h0, ed, ee, el, enw, enr);
    do_cmd(2'b00, 4'd9, 16'h0, 5, d, e, lat, nw, nr, uns);
    n_cmp++;
    if (uns !== 0 || d !== ed || e !== 1'b0 || lat !== 3) begin
      n_fail++;
      $display("FAIL backpressure: got unstable=%0d d=%h e=%b lat=%0d want unstable=0 d=%h e=0 lat=3",
               uns, d, e, lat, ed);
    end
    n_cmp++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL backpressure_release: got vld=%b rdy=%b want 0/1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_reset_mid_rmw();
    logic [15:0] d, ed; logic e, ee; int lat, el, nw, nr, enw, enr, uns, bad, w;
    w = 0; bad = 0;
    while (cmd_ready !== 1'b1 && w < 20) begin @(posedge clk); #1; w++; end
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_addr = 4'd7; cmd_data = 16'hFFFF;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      if (w_en !== 1'b0 || r_en !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b0) bad++;
    end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (w_en !== 1'b0 || rsp_valid !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL reset_abort: got %0d bad cycles want 0", bad);
    end
    model_cmd(2'b00, 4'd7, 16'h0, ed, ee, el, enw, enr);
    do_cmd(2'b00, 4'd7, 16'h0, 0, d, e, lat, nw, nr, uns);
    n_cmp++;
    if (d !== 16'hA007 || d !== ed || e !== 1'b0) begin
      n_fail++; $display("FAIL reset_old_value: got d=%h e=%b want d=a007 e=0", d, e);
    end
  endtask

  task automatic test_random();
    logic [1:0] op; logic [3:0] a; logic [15:0] dat, d, ed; logic e, ee;
    int lat, el, nw, nr, enw, enr, uns, hold;
    for (int k = 0; k < 60; k++) begin
      op = 2'($urandom_range(0, 3));
      a = 4'($urandom_range(0, 15));
      dat = 16'($urandom);
      hold = $urandom_range(0, 2);
      model_cmd(op, a, dat, ed, ee, el, enw, enr);
      do_cmd(op, a, dat, hold, d, e, lat, nw, nr, uns);
      n_cmp++;
      if (d !== ed || e !== ee || lat !== el || nw !== enw || nr !== enr || uns !== 0) begin
        n_fail++;
        $display("FAIL random_%0d op=%0d a=%0d: got d=%h e=%b lat=%0d nw=%0d nr=%0d uns=%0d want d=%h e=%b lat=%0d nw=%0d nr=%0d",
                 k, op, a, d, e, lat, nw, nr, uns, ed, ee, el, enw, enr);
      end
    end
  endtask

  task automatic test_exclusive();
    n_cmp++;
    if (overlap !== 0) begin
      n_fail++; $display("FAIL ren_wen_overlap: got %0d cycles want 0", overlap);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_rmw();
    test_out_of_range();
    test_backpressure();
    test_reset_mid_rmw();
    test_random();
    test_exclusive();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
